// File: rtl/ccip_tx_c1_throttle.sv
// Elastic buffer on the CCI-P Tx C1 write-request path with early almost-full toward the AFU.
// Optional statistics counters are built only when CCIP_TX_THROTTLE_STATS_EN is defined.
module ccip_tx_c1_throttle #(
    parameter int HDR_W      = 80,
    parameter int DATA_W     = 512,
    parameter int DEPTH_LOG2 = 6,
    parameter int AF_SLACK   = 8
) (
    input  logic                  pClk,
    input  logic                  pck_cp2af_softReset,
    input  logic                  in_valid,
    input  logic [HDR_W-1:0]      in_hdr,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_almFull,
    input  logic                  c1TxAlmFull,
    output logic                  out_valid,
    output logic [HDR_W-1:0]      out_hdr,
    output logic [DATA_W-1:0]     out_data,
    output logic [DEPTH_LOG2:0]   occupancy,
    output logic                  overflow_err,
    output logic [31:0]           stall_cycles,
    output logic [DEPTH_LOG2:0]   max_occupancy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int ENT_W = HDR_W + DATA_W;
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AF_THRESH = (DEPTH_LOG2+1)'(DEPTH - AF_SLACK);

    logic [ENT_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write while draining.
    assign full = (count == FULL_CNT);
    assign pop  = (count != '0) && !c1TxAlmFull;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage array carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge pClk) begin
        if (push) begin
            mem[wr_ptr] <= {in_hdr, in_data};
        end
    end

    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
            in_almFull   <= 1'b1;
            out_valid    <= 1'b0;
            out_hdr      <= '0;
            out_data     <= '0;
        end else begin
            count      <= count_next;
            in_almFull <= (count_next >= AF_THRESH);
            out_valid  <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr              <= rd_ptr + 1'b1;
                {out_hdr, out_data} <= mem[rd_ptr];
            end
            if (drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    assign occupancy = count;

`ifdef CCIP_TX_THROTTLE_STATS_EN
    logic [31:0]         stall_q;
    logic [DEPTH_LOG2:0] max_q;

    // max tracks the post-update count so it never lags the visible occupancy.
    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            stall_q <= '0;
            max_q   <= '0;
        end else begin
            if ((count != '0) && c1TxAlmFull && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (count_next > max_q) begin
                max_q <= count_next;
            end
        end
    end

    assign stall_cycles  = stall_q;
    assign max_occupancy = max_q;
`else
    assign stall_cycles  = '0;
    assign max_occupancy = '0;
`endif

endmodule
